// File: rtl/pzbcm_slicer_arbiter.sv
// Round-robin packet arbiter: the grant locks onto a requester until its last beat is taken,
// and beats leave through a 2-entry register slice (1-cycle latency, 1 beat/cycle, registered ready).
module pzbcm_slicer_arbiter #(
   parameter int  REQUESTERS = 2,
   parameter int  WIDTH      = 1,
   parameter type TYPE       = logic [WIDTH-1:0],
   parameter int  IDW        = $clog2(REQUESTERS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [REQUESTERS-1:0] i_valid,
   output logic [REQUESTERS-1:0] o_ready,
   input  TYPE                   i_data [REQUESTERS],
   input  logic [REQUESTERS-1:0] i_last,
   output logic                  o_valid,
   input  logic                  i_ready,
   output TYPE                   o_data,
   output logic                  o_last,
   output logic [IDW-1:0]        o_id
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef struct packed {
      TYPE            data;
      logic           last;
      logic [IDW-1:0] id;
   } slot_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   slot_t          slot0_q, slot0_d;
   slot_t          slot1_q, slot1_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           space_q, space_d;

   logic           gnt_vld;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] scan_idx;
   logic           accept;
   logic           pop;
   slot_t          new_slot;

   // Scan from the highest offset down so the requester nearest ptr wins.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_id   = '0;
      scan_idx = '0;
      if (state_q == LOCKED) begin
         gnt_vld = 1'b1;
         gnt_id  = owner_q;
      end else begin
         for (int k = REQUESTERS - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(ptr_q) + k) % REQUESTERS);
            if (i_valid[scan_idx]) begin
               gnt_vld = 1'b1;
               gnt_id  = scan_idx;
            end
         end
      end
   end

   // Ready only depends on registered space, so i_ready never reaches o_ready.
   always_comb begin
      o_ready = '0;
      if (gnt_vld && i_rst_n) begin
         o_ready[gnt_id] = space_q;
      end
   end

   assign accept   = gnt_vld && i_valid[gnt_id] && space_q;
   assign pop      = o_valid && i_ready;
   assign new_slot = '{data: i_data[gnt_id], last: i_last[gnt_id], id: gnt_id};

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (accept) begin
         if (i_last[gnt_id]) begin
            state_d = IDLE;
            ptr_d   = (gnt_id == IDW'(REQUESTERS - 1)) ? '0 : gnt_id + 1'b1;
         end else begin
            state_d = LOCKED;
            owner_d = gnt_id;
         end
      end
   end

   // Slot0 is always the head; a push with a simultaneous pop can only happen with one entry.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      cnt_d   = cnt_q;
      case ({accept, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               slot0_d = new_slot;
            end else begin
               slot1_d = new_slot;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            cnt_d   = cnt_q - 2'd1;
         end
         2'b11: begin
            slot0_d = new_slot;
         end
         default: begin
         end
      endcase
      space_d = (cnt_d != 2'd2);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         cnt_q   <= 2'd0;
         space_q <= 1'b1;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         cnt_q   <= cnt_d;
         space_q <= space_d;
      end
   end

   assign o_valid = (cnt_q != 2'd0);
   assign o_data  = slot0_q.data;
   assign o_last  = slot0_q.last;
   assign o_id    = slot0_q.id;

endmodule
